block_accumulator: RTL
======================

Name: block_accumulator

Overview:
Sequential front-end that consumes a stream of 16-bit operands and produces one 16-bit sum per block of BLOCK_LEN accepted operands. All additions go through one instance of the team's combinational adder_16bit, which the block wraps with an accumulator register, a sample counter, a sticky overflow flag and valid/ready/ack handshakes. It sits between the operand source and the result consumer in the arithmetic datapath.

Parameters:
BLOCK_LEN, 4, number of accepted operands summed per result; legal range 2..256.
CNT_BITS, $clog2(BLOCK_LEN), sample counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort; discards the partial block and any pending result.
data_in  input  16  operand.
data_valid  input  1  data_in is valid this cycle.
data_ready  output  1  block accepts an operand this cycle.
result_sum  output  16  block sum, modulo 2^16.
result_ovf  output  1  at least one carry-out occurred within the block.
result_valid  output  1  result_sum and result_ovf are valid; held until acknowledged.
result_ack  input  1  consumer takes the result.

Behaviour:
- Reset (n_rst=0, asynchronous): state=ACCUM; acc=0; cnt=0; sticky=0; result_sum=0; result_ovf=0; result_valid=0; data_ready=1 once out of reset.
- Outputs are Moore: data_ready = (state==ACCUM); result_valid = (state==RESULT). result_sum and result_ovf are registers.
- Accept = data_valid & data_ready. Only accepted operands affect state. data_in is ignored in all other cycles.
- Adder hookup: a=acc, b=data_in, carry_in=0. sum gives next_acc and overflow gives carry.
- ACCUM, accept, cnt<BLOCK_LEN-1: acc<=next_acc; sticky<=sticky|carry; cnt<=cnt+1.
- ACCUM, accept, cnt==BLOCK_LEN-1: result_sum<=next_acc; result_ovf<=sticky|carry; acc<=0; cnt<=0; sticky<=0; next state RESULT.
- Latency: result_valid rises on the clock edge that accepts the last operand, so it is visible in the following cycle.
- RESULT: data_ready=0 (backpressure). result_sum and result_ovf stay stable until ack.
- RESULT, result_ack=1: next state ACCUM. result_sum and result_ovf keep their value; only result_valid drops.
- ACCUM cannot accept in the ack cycle. The first operand of the next block is accepted in the cycle after the ack at the earliest.
- result_ack outside RESULT has no effect.
- Arithmetic wraps modulo 2^16. Overflow is any adder carry-out within the block. A wrap is never saturated.
- clear=1 (synchronous, priority over accept and ack): acc=0, cnt=0, sticky=0, state=ACCUM, result_valid=0. result_sum and result_ovf hold their values. Any operand presented in that cycle is dropped.
- Reset asserted mid-block or mid-RESULT: all of the above reset values apply immediately, and the partial block is lost.
- Data gaps (data_valid low between operands) do not change the result.

Decomposition:
- Package accum_pkg: typedef enum logic {ACCUM, RESULT} accum_state_t; localparam WORD_BITS=16.
- Sub-module: one adder_16bit instance (ports a, b, carry_in, sum, overflow), reused unchanged.
- All remaining logic lives in one module: state register, counter, acc and sticky registers, and output registers.

Test Plan:
- BLOCK_LEN=4, operands 1,2,3,4 back-to-back, ack held at 1 → result_valid for 1 cycle after 4th accept, result_sum=0x000A, result_ovf=0.
- Operands 0xFFFF,0x0001,0x0000,0x0000 → result_sum=0x0000, result_ovf=1. The next block 1,1,1,1 → 0x0004, result_ovf=0, which proves sticky was cleared.
- Backpressure: block 5,5,5,5 with ack=0 and data_valid=1, data_in=0x0007 held → data_ready=0 and result 0x0014 stable for 3 cycles. Ack → data_ready=1 the cycle after ack, and 0x0007 is accepted as the first operand.
- Gaps: operands 0x1000,0x2000,0x3000,0x4000 with 2 idle cycles between each → result_sum=0xA000, result_ovf=0, with identical latency after the last accept.
- clear after accepting 7,8, then 1,1,1,1 → result_sum=0x0004. clear asserted during RESULT → result_valid drops next cycle and data_ready=1.
- n_rst pulsed low asynchronously mid-block (after 2 operands) → all outputs take reset values at once. After release, block 2,2,2,2 → 0x0008.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and widths for the block accumulator datapath.
package accum_pkg;

   typedef enum logic {ACCUM, RESULT} accum_state_t;

   localparam int unsigned WORD_BITS = 16;

endpackage

// File: rtl/adder_16bit.sv
// Combinational 16-bit adder with carry-in; overflow is the carry-out.
module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carry_in,
   output logic [15:0] sum,
   output logic        overflow
);

   logic [16:0] w_full;

   assign w_full   = {1'b0, a} + {1'b0, b} + {16'b0, carry_in};
   assign sum      = w_full[15:0];
   assign overflow = w_full[16];

endmodule

// File: rtl/block_accumulator.sv
// Sums BLOCK_LEN accepted operands per result through one shared adder,
// with a sticky carry flag and a result held until acknowledged.
module block_accumulator
   import accum_pkg::*;
#(
   parameter  int unsigned BLOCK_LEN = 4,
   localparam int unsigned CNT_BITS  = $clog2(BLOCK_LEN)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic [WORD_BITS-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [WORD_BITS-1:0] result_sum,
   output logic                 result_ovf,
   output logic                 result_valid,
   input  logic                 result_ack
);

   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BLOCK_LEN - 1);

   accum_state_t         r_state;
   logic [WORD_BITS-1:0] r_acc;
   logic [CNT_BITS-1:0]  r_cnt;
   logic                 r_sticky;
   logic [WORD_BITS-1:0] r_sum;
   logic                 r_ovf;

   logic [WORD_BITS-1:0] w_next_acc;
   logic                 w_carry;
   logic                 w_accept;

   adder_16bit u_adder (
      .a        (r_acc),
      .b        (data_in),
      .carry_in (1'b0),
      .sum      (w_next_acc),
      .overflow (w_carry)
   );

   assign data_ready   = (r_state == ACCUM);
   assign result_valid = (r_state == RESULT);
   assign result_sum   = r_sum;
   assign result_ovf   = r_ovf;
   assign w_accept     = data_valid & data_ready;

   // clear outranks both accept and ack; the last published result is kept
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= ACCUM;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
         r_sum    <= '0;
         r_ovf    <= 1'b0;
      end else if (clear) begin
         r_state  <= ACCUM;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else if (r_state == ACCUM) begin
         if (w_accept) begin
            if (r_cnt == LAST_CNT) begin
               r_sum    <= w_next_acc;
               r_ovf    <= r_sticky | w_carry;
               r_acc    <= '0;
               r_cnt    <= '0;
               r_sticky <= 1'b0;
               r_state  <= RESULT;
            end else begin
               r_acc    <= w_next_acc;
               r_sticky <= r_sticky | w_carry;
               r_cnt    <= r_cnt + 1'b1;
            end
         end
      end else begin
         if (result_ack) begin
            r_state <= ACCUM;
         end
      end
   end

endmodule
